// File: rtl/vga_line_prefetch.sv
// vga_line_prefetch: line-buffered pixel source for the VGA timing controller.
// Line y+1 is fetched from word-addressed memory into one half of a ping-pong
// buffer while line y is shown from the other half. Pixels come back one cycle
// after the request. A pixel that is not yet in the buffer shows as black and
// sets the sticky underflow flag.
module vga_line_prefetch #(
  parameter int H_ACT     = 640,
  parameter int V_ACT     = 480,
  parameter int BASE_ADDR = 0,
  parameter int MAX_OUTST = 8
) (
  input  logic        iCLK,
  input  logic        iRST_N,
  input  logic        iVS,
  input  logic        iRequest,
  input  logic [10:0] iX,
  input  logic [10:0] iY,
  output logic [9:0]  oRed,
  output logic [9:0]  oGreen,
  output logic [9:0]  oBlue,
  output logic        oRd_req,
  output logic [21:0] oRd_addr,
  input  logic        iRd_ack,
  input  logic        iRd_valid,
  input  logic [29:0] iRd_data,
  output logic        oUnderflow,
  output logic        oOverrun
);

  // Count width holds 0..H_ACT, index width addresses 0..H_ACT-1.
  localparam int CW = $clog2(H_ACT + 1);
  localparam int AW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int OW = $clog2(MAX_OUTST + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_FETCH = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [10:0]   line_q, line_d;
  logic          bank_q, bank_d;
  logic [CW-1:0] issue_q, issue_d;
  logic [CW-1:0] ret_q, ret_d;
  logic [OW-1:0] outst_q, outst_d;
  logic [CW-1:0] fill_q [2];
  logic [CW-1:0] fill_d [2];
  logic          vs_q, req_q;
  logic          under_q, under_d;
  logic          over_q, over_d;
  logic          hit_q, hit_d;
  logic          disp_q;

  logic          frame_trig, line_trig, trig;
  logic          in_fetch, rd_req, issue, vacc, done;
  logic [10:0]   next_line;
  logic [CW-1:0] fill_disp;
  logic          miss;
  logic [AW-1:0] rd_idx;
  logic [21:0]   line_base;
  logic [29:0]   pix;

  assign frame_trig = vs_q & ~iVS;
  assign line_trig  = iRequest & ~req_q & (iY < 11'(V_ACT - 1));
  assign trig       = frame_trig | line_trig;
  assign next_line  = iY + 11'd1;

  assign in_fetch = (state_q == ST_FETCH);
  assign rd_req   = in_fetch & (issue_q < CW'(H_ACT)) & (outst_q < OW'(MAX_OUTST));
  assign issue    = rd_req & iRd_ack;
  // Returns are only meaningful during a fetch; anything else is stale data.
  assign vacc     = in_fetch & iRd_valid;
  assign done     = vacc & (ret_q == CW'(H_ACT - 1));

  assign line_base = 22'(line_q) * 22'(H_ACT);
  assign oRd_req   = rd_req;
  assign oRd_addr  = rd_req ? (22'(BASE_ADDR) + line_base + 22'(issue_q)) : '0;

  // Pixel lookup: fill is sampled before this cycle's write, so a word landing
  // in the same cycle still counts as missing.
  assign fill_disp = iY[0] ? fill_q[1] : fill_q[0];
  assign hit_d     = iRequest & (iX < 11'(fill_disp));
  assign miss      = iRequest & ~hit_d;
  assign rd_idx    = (iX < 11'(H_ACT)) ? iX[AW-1:0] : '0;

  // Fetch sequencing, fill bookkeeping and sticky flags.
  always_comb begin
    state_d   = state_q;
    line_d    = line_q;
    bank_d    = bank_q;
    issue_d   = issue_q + CW'(issue);
    ret_d     = ret_q + CW'(vacc);
    fill_d[0] = fill_q[0];
    fill_d[1] = fill_q[1];
    outst_d   = outst_q;
    over_d    = over_q;
    if (issue && !vacc) outst_d = outst_q + OW'(1);
    if (!issue && vacc) outst_d = outst_q - OW'(1);
    if (vacc) fill_d[bank_q] = fill_q[bank_q] + CW'(1);
    if (done) state_d = ST_IDLE;
    if (trig) begin
      if (in_fetch && !done) begin
        // Busy: drop the trigger but remember that it happened.
        over_d = 1'b1;
      end else begin
        state_d = ST_FETCH;
        issue_d = '0;
        ret_d   = '0;
        if (frame_trig) begin
          line_d    = '0;
          bank_d    = 1'b0;
          fill_d[0] = '0;
          fill_d[1] = '0;
          over_d    = 1'b0;
        end else begin
          line_d                 = next_line;
          bank_d                 = next_line[0];
          fill_d[next_line[0]]   = '0;
        end
      end
    end
    // A miss in the same cycle as a new frame still gets reported.
    under_d = (frame_trig ? 1'b0 : under_q) | miss;
  end

  // State and control registers.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q   <= ST_IDLE;
      line_q    <= '0;
      bank_q    <= 1'b0;
      issue_q   <= '0;
      ret_q     <= '0;
      outst_q   <= '0;
      fill_q[0] <= '0;
      fill_q[1] <= '0;
      vs_q      <= 1'b0;
      req_q     <= 1'b0;
      under_q   <= 1'b0;
      over_q    <= 1'b0;
      hit_q     <= 1'b0;
      disp_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      bank_q    <= bank_d;
      issue_q   <= issue_d;
      ret_q     <= ret_d;
      outst_q   <= outst_d;
      fill_q[0] <= fill_d[0];
      fill_q[1] <= fill_d[1];
      vs_q      <= iVS;
      req_q     <= iRequest;
      under_q   <= under_d;
      over_q    <= over_d;
      hit_q     <= hit_d;
      disp_q    <= iY[0];
    end
  end

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
      logic [29:0] mem [H_ACT];
      logic [29:0] rd_q;
      logic        we;
      assign we = vacc & (bank_q == 1'(gi));
      // Line buffer: returned words written in order, displayed pixel read through a register.
      always_ff @(posedge iCLK) begin
        if (we) mem[ret_q[AW-1:0]] <= iRd_data;
        rd_q <= mem[rd_idx];
      end
    end
  endgenerate

  assign pix        = hit_q ? (disp_q ? g_bank[1].rd_q : g_bank[0].rd_q) : '0;
  assign oRed       = pix[29:20];
  assign oGreen     = pix[19:10];
  assign oBlue      = pix[9:0];
  assign oUnderflow = under_q;
  assign oOverrun   = over_q;

endmodule
